serial_pattern_tx: RTL and testbench

Serial bit-stream transmitter. Accepts a parallel word plus a bit count and shifts the word out MSB-first, one bit per clock, on a single-bit line. Drives the serial input of the team's downstream Mealy pattern detectors (e.g. the "101" detector). Used in test harnesses and link bring-up to generate known bit sequences.

---
 rtl/serial_pattern_tx.sv | 117 +++++++++++
 tb/tb_serial_pattern_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first serial transmitter of a parallel word with a programmable bit count
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      frame request, taken when ready is high
//   data       payload; low len_eff bits are sent, bit len_eff-1 first
//   len        bit count; 0 or >WIDTH selects WIDTH (len_eff)
//   ready      high when a start would be accepted this cycle
//   out        serial bit (registered)
//   out_valid  out carries a frame bit (registered)
//   done       pulse with the last payload bit of a frame (registered)
//
// Optional feature macro: PREAMBLE_EN prefixes every frame with the marker 1,0,1.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);
  localparam logic [LEN_W-1:0] W_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] TWO = LEN_W'(2);
`ifdef PREAMBLE_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PRE} state_t;
  logic [1:0] pre_q;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [LEN_W-1:0] cnt_q;
  logic             out_q;
  logic             out_valid_q;
  logic             done_q;
  logic [LEN_W-1:0] len_eff;
  logic [WIDTH-1:0] sr_load;
  logic             accept;
  assign len_eff   = (len == '0 || len > W_L) ? W_L : len;
  // left-align the payload so its first bit sits at the MSB
  assign sr_load   = data << (W_L - len_eff);
  assign ready     = state_q == IDLE || (state_q == SHIFT && cnt_q == ONE);
  assign accept    = start && ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  // sr_q holds only the payload bits not yet placed on the line, MSB next;
  // cnt_q counts payload bits remaining including the one currently on out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef PREAMBLE_EN
      pre_q       <= 2'd0;
`endif
    end else if (accept) begin
      cnt_q       <= len_eff;
      out_valid_q <= 1'b1;
`ifdef PREAMBLE_EN
      state_q     <= PRE;
      sr_q        <= sr_load;
      pre_q       <= 2'd0;
      out_q       <= 1'b1;
      done_q      <= 1'b0;
`else
      state_q     <= SHIFT;
      sr_q        <= sr_load << 1;
      out_q       <= sr_load[WIDTH-1];
      done_q      <= len_eff == ONE;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q > ONE) begin
            sr_q   <= sr_q << 1;
            out_q  <= sr_q[WIDTH-1];
            cnt_q  <= cnt_q - ONE;
            done_q <= cnt_q == TWO;
          end else begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
          end
        end
`ifdef PREAMBLE_EN
        PRE: begin
          if (pre_q == 2'd2) begin
            state_q <= SHIFT;
            sr_q    <= sr_q << 1;
            out_q   <= sr_q[WIDTH-1];
            done_q  <= cnt_q == ONE;
          end else begin
            pre_q <= pre_q + 2'd1;
            // marker 1,0,1: bit 1 is the only zero
            out_q <= pre_q != 2'd0;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed, self-checking bench with a queue-based line model
module tb_serial_pattern_tx;
  logic       clk = 0;
  logic       reset, start;
  logic [7:0] data;
  logic [3:0] len;
  logic       ready, out, out_valid, done;
  int         tests = 0;
  int         fails = 0;
  bit         run = 0;
`ifdef PREAMBLE_EN
  localparam int PRE_N = 3;
`else
  localparam int PRE_N = 0;
`endif

  serial_pattern_tx #(.WIDTH(8), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data), .len(len),
    .ready(ready), .out(out), .out_valid(out_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, g, e, $time);
    end
  endtask

  // Line model: pending symbols {bit, last} still to appear, one per clock.
  logic [1:0] pend[$];
  logic       cur_v, cur_b, cur_d;
  int         m_le;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
      {cur_v, cur_b, cur_d} = 3'b000;
    end else begin
      if (start && pend.size() == 0) begin
        m_le = (len == 0 || len > 8) ? 8 : int'(len);
`ifdef PREAMBLE_EN
        pend.push_back(2'b10);
        pend.push_back(2'b00);
        pend.push_back(2'b10);
`endif
        for (int i = m_le - 1; i >= 0; i--) pend.push_back({data[i], i == 0});
      end
      if (pend.size() != 0) begin
        {cur_b, cur_d} = pend.pop_front();
        cur_v = 1'b1;
      end else {cur_v, cur_b, cur_d} = 3'b000;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("line_out", out, cur_b);
      chk("line_valid", out_valid, cur_v);
      chk("line_done", done, cur_d);
      chk("line_ready", ready, pend.size() == 0);
    end
  end

  // Frame collector: gathers valid bits until done.
  typedef struct {logic [31:0] b; int n; int c;} fr_t;
  fr_t         fr_q[$];
  logic [31:0] got;
  int          gn, cyc;
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      got = 0;
      gn  = 0;
    end else begin
      cyc++;
      if (out_valid) begin
        got = {got[30:0], out};
        gn++;
        if (done) begin
          fr_q.push_back('{got, gn, cyc});
          got = 0;
          gn  = 0;
        end
      end
    end
  end

`ifdef PREAMBLE_EN
  logic [1:0] hist = 2'b00;
  logic       det;
  always @(posedge clk) hist <= out_valid ? {hist[0], out} : 2'b00;
  assign det = out_valid && out && hist == 2'b10;
`endif

  task automatic send(input logic [7:0] d, input logic [3:0] l);
    @(posedge clk);
    #1 data = d; len = l; start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_frame(input string nm);
    int k = 0;
    while (fr_q.size() == 0 && k < 40) begin
      @(negedge clk);
      #1 k++;
    end
    if (fr_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no frame expected one within 40 cycles", nm);
    end
  endtask

  task automatic check_frame(input string nm, input logic [31:0] payload, input int n, output int c);
    fr_t         f;
    logic [31:0] eb = payload;
`ifdef PREAMBLE_EN
    eb |= 32'h5 << n;
`endif
    c = 0;
    if (fr_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_missing: got no frame expected %0h", nm, eb);
    end else begin
      f = fr_q.pop_front();
      c = f.c;
      chk({nm, "_bits"}, f.b, eb);
      chk({nm, "_len"}, f.n, n + PRE_N);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2;
    start = 0; data = 0; len = 0; reset = 0;
    #1 reset = 1;
    run = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 1);
    reset = 0;
    // 1: basic full-width frame
    send(8'hA5, 4'd0);
    wait_frame("t1");
    check_frame("t1", 32'hA5, 8, c1);
    // 2: short frames
    send(8'h05, 4'd3);
    wait_frame("t2a");
    check_frame("t2a", 32'h5, 3, c1);
    send(8'h01, 4'd1);
    wait_frame("t2b");
    check_frame("t2b", 32'h1, 1, c1);
    // len above WIDTH behaves as WIDTH
    send(8'h96, 4'd12);
    wait_frame("t2c");
    check_frame("t2c", 32'h96, 8, c1);
    // 3: back-to-back, start held high
    @(posedge clk);
    #1 data = 8'hF0; len = 4'd8; start = 1;
    @(posedge clk);
    #1 data = 8'h0F;
    repeat (8 + PRE_N) @(posedge clk);
    #1 start = 0;
    wait_frame("t3a");
    check_frame("t3a", 32'hF0, 8, c1);
    wait_frame("t3b");
    check_frame("t3b", 32'h0F, 8, c2);
    chk("t3_gap", c2 - c1, 8 + PRE_N);
    // 4: start while busy is ignored
    send(8'hA5, 4'd0);
    repeat (2) @(posedge clk);
    #1 data = 8'h3C; len = 4'd8; start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_frame("t4");
    check_frame("t4", 32'hA5, 8, c1);
    @(negedge clk);
    chk("t4_idle_valid", out_valid, 0);
    chk("t4_frames", fr_q.size(), 0);
    // 5: asynchronous reset mid-frame
    send(8'hFF, 4'd8);
    repeat (2) @(posedge clk);
    #3 reset = 1;
    #1;
    chk("t5_out", out, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("t5_nodone", fr_q.size(), 0);
    send(8'h81, 4'd8);
    wait_frame("t5");
    check_frame("t5", 32'h81, 8, c1);
`ifdef PREAMBLE_EN
    // 6: preamble marker seen by a 101 detector on the third cycle
    repeat (2) @(posedge clk);
    send(8'h03, 4'd2);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("t6_det", det, j == 3);
    end
    wait_frame("t6");
    check_frame("t6", 32'h3, 2, c1);
`endif
    repeat (3) @(posedge clk);
    run = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
